// File: rtl/packet_width_reducer.sv
// 64->32 transmit-side packet width reducer: serializes each wide beat MSW first
// and regenerates sop/eop/residual/bad on the narrow bus. Option: PKT_WIDTH_REDUCER_BAD_DROP_EN.
module packet_width_reducer #(
  parameter int INPUT_WIDTH  = 64,
  parameter int OUTPUT_WIDTH = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic                    ivalid,
  output logic                    iready,
  input  logic                    isop,
  input  logic                    ieop,
  input  logic [2:0]              iresidual,
  input  logic [INPUT_WIDTH-1:0]  idata,
  input  logic                    ibad,
  output logic                    ovalid,
  input  logic                    oready,
  output logic                    osop,
  output logic                    oeop,
  output logic [1:0]              oresidual,
  output logic [OUTPUT_WIDTH-1:0] odata,
  output logic                    obad,
  output logic [CNT_WIDTH-1:0]    opkt_cnt,
  output logic                    oerr_seq
);

`ifdef PKT_WIDTH_REDUCER_BAD_DROP_EN
  localparam logic DROP_BAD = 1'b1;
`else
  localparam logic DROP_BAD = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {EMPTY = 2'd0, UPPER = 2'd1, LOWER = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] lower_q, lower_d;
  logic                    eop_q, eop_d;
  logic [2:0]              res_q, res_d;
  logic                    in_pkt_q, in_pkt_d;
  logic                    bad_q, bad_d;
  logic                    drop_q, drop_d;
  logic                    ovalid_q, ovalid_d;
  logic                    osop_q, osop_d;
  logic                    oeop_q, oeop_d;
  logic [1:0]              ores_q, ores_d;
  logic [OUTPUT_WIDTH-1:0] odata_q, odata_d;
  logic                    obad_q, obad_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic       out_last_s;
  logic       free_s;
  logic       accept_s;
  logic       load_s;
  logic [2:0] res_m4_s;

  // Handshake, packet tracking, next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    lower_d  = lower_q;
    eop_d    = eop_q;
    res_d    = res_q;
    in_pkt_d = in_pkt_q;
    bad_d    = bad_q;
    drop_d   = drop_q;
    ovalid_d = ovalid_q;
    osop_d   = osop_q;
    oeop_d   = oeop_q;
    ores_d   = ores_q;
    odata_d  = odata_q;
    obad_d   = obad_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    load_s   = 1'b0;
    res_m4_s = res_q - 3'd4;

    // In UPPER, oeop_q already tells whether the upper word ends the beat
    out_last_s = (state_q == LOWER) | ((state_q == UPPER) & oeop_q);
    free_s     = (state_q == EMPTY) | (oready & ovalid_q & out_last_s);
    iready     = ~irst & free_s;
    accept_s   = ivalid & iready;

    if (accept_s) begin
      if (isop) begin
        if (in_pkt_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        in_pkt_d = ~ieop;
        bad_d    = ibad;
        drop_d   = DROP_BAD & ibad & ~ieop;
        load_s   = ~(DROP_BAD & ibad);
      end else if (~in_pkt_q) begin
        err_d = 1'b1;
      end else begin
        load_s = ~drop_q;
        if (ieop) begin
          in_pkt_d = 1'b0;
          drop_d   = 1'b0;
        end else begin
          in_pkt_d = 1'b1;
        end
      end
    end else begin
      load_s = 1'b0;
    end

    if (ovalid_q & oready & oeop_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      EMPTY, UPPER, LOWER: begin
        if (free_s) begin
          if (load_s) begin
            state_d  = UPPER;
            ovalid_d = 1'b1;
            odata_d  = idata[INPUT_WIDTH-1:OUTPUT_WIDTH];
            lower_d  = idata[OUTPUT_WIDTH-1:0];
            eop_d    = ieop;
            res_d    = iresidual;
            osop_d   = isop;
            oeop_d   = ieop & (iresidual != 3'd0) & (iresidual <= 3'd4);
            ores_d   = (ieop & (iresidual != 3'd0) & (iresidual <= 3'd4)) ? iresidual[1:0] : 2'd0;
            obad_d   = DROP_BAD ? 1'b0 : (isop ? ibad : bad_q);
          end else begin
            state_d  = EMPTY;
            ovalid_d = 1'b0;
            osop_d   = 1'b0;
            oeop_d   = 1'b0;
            ores_d   = 2'd0;
          end
        end else if ((state_q == UPPER) & oready) begin
          state_d = LOWER;
          odata_d = lower_q;
          osop_d  = 1'b0;
          oeop_d  = eop_q;
          ores_d  = eop_q ? res_m4_s[1:0] : 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = EMPTY;
        ovalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= EMPTY;
      lower_q  <= '0;
      eop_q    <= 1'b0;
      res_q    <= 3'd0;
      in_pkt_q <= 1'b0;
      bad_q    <= 1'b0;
      drop_q   <= 1'b0;
      ovalid_q <= 1'b0;
      osop_q   <= 1'b0;
      oeop_q   <= 1'b0;
      ores_q   <= 2'd0;
      odata_q  <= '0;
      obad_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lower_q  <= lower_d;
      eop_q    <= eop_d;
      res_q    <= res_d;
      in_pkt_q <= in_pkt_d;
      bad_q    <= bad_d;
      drop_q   <= drop_d;
      ovalid_q <= ovalid_d;
      osop_q   <= osop_d;
      oeop_q   <= oeop_d;
      ores_q   <= ores_d;
      odata_q  <= odata_d;
      obad_q   <= obad_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign ovalid    = ovalid_q;
  assign osop      = osop_q;
  assign oeop      = oeop_q;
  assign oresidual = ores_q;
  assign odata     = odata_q;
  assign obad      = obad_q;
  assign opkt_cnt  = cnt_q;
  assign oerr_seq  = err_q;

endmodule

// File: tb/tb_packet_width_reducer.sv
// Bench for packet_width_reducer: vector table, directed corner sequences and
// random traffic against a byte-count reference model.
module tb_packet_width_reducer;

`ifdef PKT_WIDTH_REDUCER_BAD_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        irst, ivalid, iready, isop, ieop, ibad;
  logic [2:0]  iresidual;
  logic [63:0] idata;
  logic        ovalid, oready, osop, oeop, obad, oerr_seq;
  logic [1:0]  oresidual;
  logic [31:0] odata;
  logic [15:0] opkt_cnt;

  always #5 iclk = ~iclk;

  packet_width_reducer dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .iready(iready), .isop(isop),
    .ieop(ieop), .iresidual(iresidual), .idata(idata), .ibad(ibad),
    .ovalid(ovalid), .oready(oready), .osop(osop), .oeop(oeop),
    .oresidual(oresidual), .odata(odata), .obad(obad), .opkt_cnt(opkt_cnt),
    .oerr_seq(oerr_seq)
  );

  typedef struct {
    logic [31:0] data; logic sop; logic eop; logic [1:0] res; logic bad; int cyc;
  } word_t;

  typedef struct {
    logic isop; logic ieop; logic [2:0] ires; logic [63:0] idata;
    int nw; logic [31:0] w0; logic [31:0] w1; logic eop_l; logic [1:0] res_l;
  } vec_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rand_ready = 1'b0;
  bit    m_inpkt = 1'b0, m_bad = 1'b0, m_err = 1'b0;
  int    m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [36:0] pack(input word_t w);
    return {w.data, w.sop, w.eop, w.res, w.bad};
  endfunction

  // Reference: split an accepted beat by its valid byte count
  task automatic model_accept(input logic sop, input logic eop, input logic [2:0] res,
                              input logic [63:0] d, input logic bad);
    bit emit;
    int nbytes;
    word_t w;
    emit = 1'b0;
    if (sop) begin
      if (m_inpkt) m_err = 1'b1;
      m_bad = bad; m_inpkt = !eop;
      emit = !(DROP && bad);
    end else if (!m_inpkt) begin
      m_err = 1'b1;
    end else begin
      emit = !(DROP && m_bad);
      if (eop) m_inpkt = 1'b0;
    end
    if (emit) begin
      nbytes = (eop && res != 3'd0) ? int'(res) : 8;
      w.bad = DROP ? 1'b0 : m_bad;
      w.cyc = 0;
      w.data = d[63:32]; w.sop = sop; w.eop = eop && nbytes <= 4;
      w.res = w.eop ? 2'(nbytes % 4) : 2'd0;
      exp_q.push_back(w);
      if (nbytes > 4) begin
        w.data = d[31:0]; w.sop = 1'b0; w.eop = eop;
        w.res = eop ? 2'((nbytes - 4) % 4) : 2'd0;
        exp_q.push_back(w);
      end
    end
  endtask

  // Monitor: output handshakes vs model, stall stability, input acceptance
  initial begin : monitor
    bit prev_stall;
    logic [37:0] snap;
    word_t w, e;
    prev_stall = 1'b0;
    snap = '0;
    forever begin
      @(negedge iclk);
      cyc++;
      if (irst) begin
        exp_q.delete();
        m_inpkt = 1'b0; m_bad = 1'b0; m_err = 1'b0; m_cnt = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {ovalid, odata, osop, oeop, oresidual, obad}, snap);
        if (ovalid && oready) begin
          w.data = odata; w.sop = osop; w.eop = oeop; w.res = oresidual; w.bad = obad; w.cyc = cyc;
          obs_q.push_back(w);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL word: got %h expected none", pack(w));
          end else begin
            e = exp_q.pop_front();
            check("word", pack(w), pack(e));
            if (e.eop) m_cnt++;
          end
        end
        if (ivalid && iready) model_accept(isop, ieop, iresidual, idata, ibad);
        prev_stall = ovalid && !oready;
        snap = {ovalid, odata, osop, oeop, oresidual, obad};
      end
    end
  end

  // Random backpressure
  initial begin
    forever begin
      @(posedge iclk); #1;
      if (rand_ready) oready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic sop, input logic eop, input logic [2:0] res,
                      input logic [63:0] d, input logic bad);
    int n;
    ivalid = 1'b1; isop = sop; ieop = eop; iresidual = res; idata = d; ibad = bad;
    n = 0;
    @(negedge iclk);
    while (!iready && n < 200) begin
      n++;
      @(negedge iclk);
    end
    if (n >= 200) check("accept_timeout", 64'(n), 64'd0);
    @(posedge iclk); #1;
    ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ibad = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge iclk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge iclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    irst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      check("rst_iready_low", 64'(iready), 64'd0);
      @(posedge iclk);
    end
    #1 irst = 1'b0;
    @(negedge iclk);
    check("rst_outputs", {ovalid, osop, oeop, oresidual, odata, obad, opkt_cnt, oerr_seq}, 64'd0);
    check("rst_iready_high", 64'(iready), 64'd1);
    @(posedge iclk); #1;
  endtask

  vec_t vecs[9];

  initial begin : main
    int idx, total, nb, sz;
    irst = 1'b1; ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ibad = 1'b0;
    iresidual = 3'd0; idata = 64'd0; oready = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 3'd3, 64'hAABBCCDD_11223344, 1, 32'hAABBCCDD, 32'h0, 1'b1, 2'd3};
    vecs[1] = '{1'b1, 1'b0, 3'd0, 64'h00010203_04050607, 2, 32'h00010203, 32'h04050607, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 64'h08090A0B_0C0D0E0F, 2, 32'h08090A0B, 32'h0C0D0E0F, 1'b0, 2'd0};
    vecs[3] = '{1'b0, 1'b1, 3'd0, 64'h10111213_14151617, 2, 32'h10111213, 32'h14151617, 1'b1, 2'd0};
    vecs[4] = '{1'b1, 1'b0, 3'd0, 64'h20212223_24252627, 2, 32'h20212223, 32'h24252627, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 1'b0, 3'd0, 64'h28292A2B_2C2D2E2F, 2, 32'h28292A2B, 32'h2C2D2E2F, 1'b0, 2'd0};
    vecs[6] = '{1'b0, 1'b1, 3'd6, 64'h30313233_34353637, 2, 32'h30313233, 32'h34353637, 1'b1, 2'd2};
    vecs[7] = '{1'b1, 1'b1, 3'd4, 64'h40414243_44454647, 1, 32'h40414243, 32'h0, 1'b1, 2'd0};
    vecs[8] = '{1'b1, 1'b1, 3'd5, 64'h50515253_54555657, 2, 32'h50515253, 32'h54555657, 1'b1, 2'd1};

    // Reset, then reset again while a beat is held mid-packet under backpressure
    do_reset(3);
    send(1'b1, 1'b0, 3'd0, 64'hDEADBEEF_CAFEF00D, 1'b0);
    repeat (2) @(posedge iclk);
    #1;
    do_reset(3);
    oready = 1'b1;

    // Vector table, sent back-to-back with oready high
    obs_q.delete();
    total = 0;
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].isop, vecs[i].ieop, vecs[i].ires, vecs[i].idata, 1'b0);
      total += vecs[i].nw;
    end
    wait_drain();
    check("table_words", 64'(obs_q.size()), 64'(total));
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      if (idx < obs_q.size())
        check("table_w0", 64'(pack(obs_q[idx])),
              64'({vecs[i].w0, vecs[i].isop, (vecs[i].nw == 1) ? vecs[i].eop_l : 1'b0,
                   (vecs[i].nw == 1) ? vecs[i].res_l : 2'd0, 1'b0}));
      idx++;
      if (vecs[i].nw == 2) begin
        if (idx < obs_q.size())
          check("table_w1", 64'(pack(obs_q[idx])),
                64'({vecs[i].w1, 1'b0, vecs[i].eop_l, vecs[i].res_l, 1'b0}));
        idx++;
      end
    end
    if (obs_q.size() >= 7)
      for (int k = 1; k < 6; k++)
        check("no_bubble", 64'(obs_q[k+1].cyc - obs_q[k].cyc), 64'd1);
    check("table_pkt_cnt", 64'(opkt_cnt), 64'd5);

    // Random traffic with 50% backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge iclk); #1;
        end
        send(b == 0, b == nb - 1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, 1'b0);
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    oready = 1'b1;
    check("rand_pkt_cnt", 64'(opkt_cnt), 64'd105);
    check("model_pkt_cnt", 64'(opkt_cnt), 64'(m_cnt));
    check("err_clean", 64'(oerr_seq), 64'd0);

    // Missing eop, then a new sop
    send(1'b1, 1'b0, 3'd0, 64'h60616263_64656667, 1'b0);
    send(1'b1, 1'b1, 3'd2, 64'h70717273_74757677, 1'b0);
    wait_drain();
    check("err_missing_eop", 64'(oerr_seq), 64'd1);
    send(1'b1, 1'b1, 3'd0, 64'h80818283_84858687, 1'b0);
    wait_drain();
    check("err_sticky", 64'(oerr_seq), 64'(m_err));
    check("err_pkt_cnt", 64'(opkt_cnt), 64'd107);

    // Continuation beat outside any packet is discarded
    do_reset(2);
    obs_q.delete();
    send(1'b0, 1'b1, 3'd1, 64'h90919293_94959697, 1'b0);
    wait_drain();
    check("orphan_no_output", 64'(obs_q.size()), 64'd0);
    check("orphan_err", 64'(oerr_seq), 64'd1);

    // Bad packet: forwarded with obad or dropped, depending on build
    do_reset(2);
    obs_q.delete();
    send(1'b1, 1'b0, 3'd0, 64'hA0A1A2A3_A4A5A6A7, 1'b1);
    send(1'b0, 1'b1, 3'd0, 64'hB0B1B2B3_B4B5B6B7, 1'b0);
    wait_drain();
    sz = obs_q.size();
    check("bad_words", 64'(sz), DROP ? 64'd0 : 64'd4);
    for (int k = 0; k < sz; k++) check("bad_flag", 64'(obs_q[k].bad), 64'd1);
    check("bad_pkt_cnt", 64'(opkt_cnt), DROP ? 64'd0 : 64'd1);
    send(1'b1, 1'b1, 3'd7, 64'hC0C1C2C3_C4C5C6C7, 1'b0);
    wait_drain();
    check("good_after_bad_cnt", 64'(opkt_cnt), DROP ? 64'd1 : 64'd2);
    check("err_after_bad", 64'(oerr_seq), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
